// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// master: datapath/decoder side. It drives the ID/EX status inputs and receives the controls.
// slave : the controller. It receives the status inputs and drives the enables, flushes,
//         issue, branch select, state and the stall counter.
interface pipeline_hazard_ctrl_if;
  logic        iValidID;
  logic        iUseA;
  logic        iUseB;
  logic        iWriteA;
  logic        iWriteB;
  logic        iLoad;
  logic        iHaltID;
  logic        iBranchTakenEX;
  logic        iResume;
  logic        oEnablePC;
  logic        oEnableIFID;
  logic        oFlushIF;
  logic        oFlushID;
  logic        oIssue;
  logic        oSelectBranchPC;
  logic [1:0]  oState;
  logic [15:0] oStallCount;

  modport master (
    output iValidID, iUseA, iUseB, iWriteA, iWriteB, iLoad, iHaltID, iBranchTakenEX, iResume,
    input  oEnablePC, oEnableIFID, oFlushIF, oFlushID, oIssue, oSelectBranchPC, oState,
           oStallCount
  );

  modport slave (
    input  iValidID, iUseA, iUseB, iWriteA, iWriteB, iLoad, iHaltID, iBranchTakenEX, iResume,
    output oEnablePC, oEnableIFID, oFlushIF, oFlushID, oIssue, oSelectBranchPC, oState,
           oStallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline controller for the IF/ID/EX/MEM/WB processor.
// - Scoreboard: one countdown per register (A, B) tracking cycles until a pending write lands.
// - Stalls PC/IF/ID on RAW/WAW hazards and flushes IF/ID on a taken branch from EX.
// - Sequences HALT/RESUME and keeps a saturating stall-cycle counter for debug.
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high; while high the controls are forced to "free run, no issue"
//   bus   : slave side of pipeline_hazard_ctrl_if (status inputs, control outputs)
module pipeline_hazard_ctrl #(
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LOAD_LAT = 3,
  parameter int unsigned LAT_W    = 2
) (
  input logic                  Clock,
  input logic                  Reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StStall = 2'b01,
    StFlush = 2'b10,
    StHalt  = 2'b11
  } state_e;

  localparam logic [LAT_W-1:0] AluLatW  = LAT_W'(ALU_LAT);
  localparam logic [LAT_W-1:0] LoadLatW = LAT_W'(LOAD_LAT);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_a_q, cnt_a_d;
  logic [LAT_W-1:0] cnt_b_q, cnt_b_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic en_pc, en_ifid, flush_if, flush_id, issue, sel_branch;

  // Writes count as well as reads so a later writer cannot land before an earlier one (WAW).
  assign hazard = bus.iValidID &
                  (((bus.iUseA | bus.iWriteA) & (cnt_a_q != '0)) |
                   ((bus.iUseB | bus.iWriteB) & (cnt_b_q != '0)));

  always_comb begin
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    issue      = bus.iValidID;
    sel_branch = 1'b0;
    state_d    = StRun;
    unique case (state_q)
      StHalt: begin
        en_pc    = 1'b0;
        en_ifid  = 1'b0;
        flush_id = 1'b1;
        issue    = 1'b0;
        state_d  = bus.iResume ? StRun : StHalt;
      end
      default: begin
        if (bus.iBranchTakenEX) begin
          sel_branch = 1'b1;
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          issue      = 1'b0;
          state_d    = StFlush;
        end else if (state_q == StFlush) begin
          // ID holds the bubble inserted by the flush; nothing to check or issue.
          issue = 1'b0;
        end else if (bus.iHaltID && bus.iValidID && !hazard) begin
          en_pc    = 1'b0;
          en_ifid  = 1'b0;
          flush_id = 1'b1;
          issue    = 1'b0;
          state_d  = StHalt;
        end else if (hazard) begin
          en_pc    = 1'b0;
          en_ifid  = 1'b0;
          flush_id = 1'b1;
          issue    = 1'b0;
          state_d  = StStall;
        end
      end
    endcase
  end

  always_comb begin
    cnt_a_d = (cnt_a_q != '0) ? cnt_a_q - 1'b1 : cnt_a_q;
    cnt_b_d = (cnt_b_q != '0) ? cnt_b_q - 1'b1 : cnt_b_q;
    if (issue && bus.iWriteA) cnt_a_d = bus.iLoad ? LoadLatW : AluLatW;
    if (issue && bus.iWriteB) cnt_b_d = bus.iLoad ? LoadLatW : AluLatW;

    stall_cnt_d = stall_cnt_q;
    if (state_q != StHalt && !en_pc && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StRun;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.oEnablePC       = Reset | en_pc;
  assign bus.oEnableIFID     = Reset | en_ifid;
  assign bus.oFlushIF        = ~Reset & flush_if;
  assign bus.oFlushID        = ~Reset & flush_id;
  assign bus.oIssue          = ~Reset & issue;
  assign bus.oSelectBranchPC = ~Reset & sel_branch;
  assign bus.oState          = state_q;
  assign bus.oStallCount     = stall_cnt_q;

endmodule
